// File: rtl/rt_sched_pkg.sv
// Types and constants shared by the schedulers that multiplex one ray-tracing
// arithmetic unit between several requesters.
package rt_sched_pkg;

  typedef logic [2:0][31:0] vec3_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above the
// pointer, wrapping modulo N; returns one-hot grant, its index and a found flag.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  localparam int KW = IW + 1;

  logic [KW-1:0] w_k;

  // Priority scan starting at the pointer; the first hit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_k     = '0;
    for (int i = 0; i < N; i++) begin
      w_k = KW'(i_ptr) + KW'(i);
      if (w_k >= KW'(N)) begin
        w_k = w_k - KW'(N);
      end else begin
        w_k = w_k;
      end
      if (!o_any && i_req[w_k[IW-1:0]]) begin
        o_any                = 1'b1;
        o_grant[w_k[IW-1:0]] = 1'b1;
        o_idx                = w_k[IW-1:0];
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule

// File: rtl/plane_int_sched.sv
// Round-robin front end for one shared plane_ray_int unit: accepts a request,
// holds its operands on the unit, waits (with watchdog) and returns tagged t.
module plane_int_sched
  import rt_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req_valid,
  output logic [NUM_REQ-1:0]  req_ready,
  input  vec3_t [NUM_REQ-1:0] req_ray_p0,
  input  vec3_t [NUM_REQ-1:0] req_ray_dir,
  input  vec3_t [NUM_REQ-1:0] req_plane_p0,
  input  vec3_t [NUM_REQ-1:0] req_plane_nrm,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [31:0]         rsp_t,
  output logic                rsp_err,
  output logic                unit_start,
  output vec3_t               unit_ray_p0,
  output vec3_t               unit_ray_dir,
  output vec3_t               unit_plane_p0,
  output vec3_t               unit_plane_nrm,
  input  logic                unit_busy,
  input  logic                unit_valid,
  input  logic [31:0]         unit_t,
  output logic                sched_busy,
  output logic [15:0]         timeout_cnt
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  sched_state_e       r_state;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_id;
  vec3_t              r_ray_p0;
  vec3_t              r_ray_dir;
  vec3_t              r_plane_p0;
  vec3_t              r_plane_nrm;
  logic               r_rsp_valid;
  logic [31:0]        r_rsp_t;
  logic               r_rsp_err;
  logic [CNT_W-1:0]   r_cnt;
  logic [15:0]        r_to_cnt;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic [ID_W-1:0]    w_next_ptr;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_next_ptr = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);

  // The grant doubles as the accept handshake, so it is only exposed in IDLE.
  assign req_ready      = (r_state == IDLE) ? w_grant : '0;
  assign unit_start     = (r_state == ISSUE) && !unit_busy;
  assign sched_busy     = (r_state != IDLE);
  assign rsp_valid      = r_rsp_valid;
  assign rsp_id         = r_id;
  assign rsp_t          = r_rsp_t;
  assign rsp_err        = r_rsp_err;
  assign unit_ray_p0    = r_ray_p0;
  assign unit_ray_dir   = r_ray_dir;
  assign unit_plane_p0  = r_plane_p0;
  assign unit_plane_nrm = r_plane_nrm;
  assign timeout_cnt    = r_to_cnt;

  // Scheduler FSM with operand, response and watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_ray_p0    <= '0;
      r_ray_dir   <= '0;
      r_plane_p0  <= '0;
      r_plane_nrm <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_t     <= 32'h0000_0000;
      r_rsp_err   <= 1'b0;
      r_cnt       <= '0;
      r_to_cnt    <= 16'h0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_id        <= w_idx;
            r_ray_p0    <= req_ray_p0[w_idx];
            r_ray_dir   <= req_ray_dir[w_idx];
            r_plane_p0  <= req_plane_p0[w_idx];
            r_plane_nrm <= req_plane_nrm[w_idx];
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!unit_busy) begin
            r_cnt   <= '0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // A result arriving on the last watchdog cycle still wins.
          if (unit_valid) begin
            r_rsp_t     <= unit_t;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            r_rsp_t     <= FP32_QNAN;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            if (r_to_cnt != 16'hFFFF) begin
              r_to_cnt <= r_to_cnt + 16'd1;
            end
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= w_next_ptr;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plane_int_sched.sv
// Bench for plane_int_sched: a fixed-latency unit stub plus a scoreboard of
// expected responses queued at each accept and compared at each response handshake.
module tb_plane_int_sched;
  import rt_sched_pkg::*;

  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int TO  = 8;
  localparam int LAT = 5;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [31:0]   t;
    logic          err;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  vec3_t [N-1:0] req_ray_p0;
  vec3_t [N-1:0] req_ray_dir;
  vec3_t [N-1:0] req_plane_p0;
  vec3_t [N-1:0] req_plane_nrm;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [IW-1:0] rsp_id;
  logic [31:0]   rsp_t;
  logic          rsp_err;
  logic          unit_start;
  vec3_t         unit_ray_p0;
  vec3_t         unit_ray_dir;
  vec3_t         unit_plane_p0;
  vec3_t         unit_plane_nrm;
  logic          unit_busy;
  logic          unit_valid = 1'b0;
  logic [31:0]   unit_t = 32'h0;
  logic          sched_busy;
  logic [15:0]   timeout_cnt;

  int   checks = 0;
  int   errors = 0;
  int   starts = 0;
  int   stub_lat = 0;
  logic dead;
  exp_t sb[$];
  int   grant_log[$];

  plane_int_sched #(.NUM_REQ(N), .ID_W(IW), .TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_ray_p0     (req_ray_p0),
    .req_ray_dir    (req_ray_dir),
    .req_plane_p0   (req_plane_p0),
    .req_plane_nrm  (req_plane_nrm),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_id         (rsp_id),
    .rsp_t          (rsp_t),
    .rsp_err        (rsp_err),
    .unit_start     (unit_start),
    .unit_ray_p0    (unit_ray_p0),
    .unit_ray_dir   (unit_ray_dir),
    .unit_plane_p0  (unit_plane_p0),
    .unit_plane_nrm (unit_plane_nrm),
    .unit_busy      (unit_busy),
    .unit_valid     (unit_valid),
    .unit_t         (unit_t),
    .sched_busy     (sched_busy),
    .timeout_cnt    (timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the unit's result: depends on operand components so a wrong latch shows.
  function automatic logic [31:0] stub_fn(vec3_t p0, vec3_t d, vec3_t pp, vec3_t nrm);
    return pp[0] ^ p0[0] ^ d[1] ^ nrm[2];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Unit stub: valid pulse LAT cycles after start unless it is playing dead.
  always @(negedge clk) begin
    if (unit_start) begin
      stub_lat   <= LAT;
      unit_t     <= stub_fn(unit_ray_p0, unit_ray_dir, unit_plane_p0, unit_plane_nrm);
      unit_valid <= 1'b0;
    end else if (stub_lat > 0) begin
      stub_lat   <= stub_lat - 1;
      unit_valid <= (stub_lat == 1) && !dead;
    end else begin
      unit_valid <= 1'b0;
    end
  end

  // Monitor: push expectations on accept, compare on response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (unit_start) starts <= starts + 1;
      if (|req_ready) begin
        chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
        for (int i = 0; i < N; i++) begin
          if (req_ready[i] && req_valid[i]) begin
            grant_log.push_back(i);
            sb.push_back('{id: IW'(i),
                           t: dead ? FP32_QNAN : stub_fn(req_ray_p0[i], req_ray_dir[i],
                                                         req_plane_p0[i], req_plane_nrm[i]),
                           err: dead});
          end
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          chk("sb_id", 32'(rsp_id), 32'(sb[0].id));
          chk("sb_t", rsp_t, sb[0].t);
          chk("sb_err", 32'(rsp_err), 32'(sb[0].err));
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic hold_until_accept(input int i);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("accept_expired", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic issue(input int i);
    req_valid[i] = 1'b1;
    hold_until_accept(i);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        n = c;
        break;
      end
    end
    if (n == 0) chk("rsp_expired", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!sched_busy && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("idle_expired", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   n;
    int   base;
    int   s0;
    logic quiet;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    unit_busy = 1'b0;
    dead      = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 3; k++) begin
        req_ray_p0[i][k]    = $urandom();
        req_ray_dir[i][k]   = $urandom();
        req_plane_p0[i][k]  = $urandom();
        req_plane_nrm[i][k] = $urandom();
      end
    end
    req_ray_p0[0]    = {32'h0, 32'h0, 32'h0};
    req_ray_dir[0]   = {32'h0, 32'h0, 32'h3F800000};
    req_plane_p0[0]  = {32'h0, 32'h0, 32'h3F800000};
    req_plane_nrm[0] = {32'h0, 32'h0, 32'h3F800000};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(sched_busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_unit_start", 32'(unit_start), 32'd0);
    chk("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
    chk("rst_unit_dir", unit_ray_dir[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single request through the 5-cycle unit.
    s0 = starts;
    issue(0);
    wait_rsp(n);
    chk("single_lat", 32'(n), 32'd7);
    chk("single_t", rsp_t, 32'h3F800000);
    chk("single_id", 32'(rsp_id), 32'd0);
    chk("single_err", 32'(rsp_err), 32'd0);
    wait_idle();
    chk("single_starts", 32'(starts - s0), 32'd1);

    // Busy unit holds the scheduler in ISSUE for three cycles.
    unit_busy = 1'b1;
    s0 = starts;
    issue(3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("busy_nostart", 32'(unit_start), 32'd0);
    end
    @(posedge clk);
    #1;
    unit_busy = 1'b0;
    @(negedge clk);
    chk("busy_start", 32'(unit_start), 32'd1);
    wait_idle();
    chk("busy_starts", 32'(starts - s0), 32'd1);

    // All requesters hold valid: pointer sits at 0 after serving requester 3.
    base = grant_log.size();
    s0 = starts;
    req_valid = '1;
    for (int c = 0; c < 600 && grant_log.size() < base + 5; c++) @(negedge clk);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_idle();
    chk("rr_count", 32'(grant_log.size() - base), 32'd5);
    if (grant_log.size() >= base + 5) begin
      for (int g = 0; g < 5; g++) chk("rr_order", 32'(grant_log[base + g]), 32'(g % N));
    end
    chk("rr_starts", 32'(starts - s0), 32'd5);

    // Backpressure: response must stay put and no new grant may appear.
    rsp_ready = 1'b0;
    issue(1);
    wait_rsp(n);
    s0 = starts;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_id", 32'(rsp_id), 32'd1);
      chk("bp_t", rsp_t, stub_fn(req_ray_p0[1], req_ray_dir[1], req_plane_p0[1], req_plane_nrm[1]));
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    chk("bp_starts", 32'(starts - s0), 32'd0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    hold_until_accept(2);
    wait_idle();

    // Dead unit: watchdog fires on the 8th WAIT cycle.
    dead = 1'b1;
    issue(0);
    wait_rsp(n);
    chk("to_lat", 32'(n), 32'd10);
    chk("to_t", rsp_t, FP32_QNAN);
    chk("to_err", 32'(rsp_err), 32'd1);
    chk("to_cnt", 32'(timeout_cnt), 32'd1);
    wait_idle();
    dead = 1'b0;

    // Reset in WAIT, then a late unit_valid must be ignored.
    issue(1);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(sched_busy), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_start", 32'(unit_start), 32'd0);
    chk("mid_rst_nrm", unit_plane_nrm[0], 32'd0);
    chk("mid_rst_to_cnt", 32'(timeout_cnt), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      quiet = quiet | rsp_valid | sched_busy;
    end
    chk("post_rst_quiet", 32'(quiet), 32'd0);

    // Recovery after reset.
    @(posedge clk);
    #1;
    issue(2);
    wait_rsp(n);
    chk("recover_lat", 32'(n), 32'd7);
    chk("recover_id", 32'(rsp_id), 32'd2);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
